mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch and load/store requesters. Accepts one request at a time from either side and arbitrates round-robin when both are pending. Drives a req/gnt/rvalid memory port with word-aligned addresses and byte enables. Sign- or zero-extends load data per the RV32I size code and flags misaligned accesses without touching memory. It sits between the multi-cycle RV32I core and the shared SRAM/bus adapter.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between instruction
// fetch and load/store, with byte-lane steering, load extension and alignment checks.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_e;

  state_e      state;
  src_e        owner;
  src_e        last_grant;
  logic [2:0]  size_q;
  logic [1:0]  off_q;

  logic              pick_fetch;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic              sel_we;
  logic              sel_err;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              d_illegal;
  logic              d_misal;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  // Fetch is treated as a word access so it shares the lane/enable logic with loads.
  always_comb begin
    pick_fetch = if_req && (!d_req || last_grant == SRC_DATA);
    sel_addr   = pick_fetch ? if_addr : d_addr;
    sel_size   = pick_fetch ? 3'b010 : d_size;
    sel_we     = pick_fetch ? 1'b0 : d_we;
    d_illegal  = d_we ? (d_size > 3'b010) : (d_size == 3'b011 || d_size[2:1] == 2'b11);
    d_misal    = (d_size[1:0] == 2'b01 && d_addr[0]) ||
                 (d_size[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
    sel_err    = pick_fetch ? (if_addr[1:0] != 2'b00) : (d_illegal || d_misal);
    case (sel_size[1:0])
      2'b00: begin
        sel_be    = 4'b0001 << sel_addr[1:0];
        sel_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        sel_be    = 4'b0011 << sel_addr[1:0];
        sel_wdata = {2{d_wdata[15:0]}};
      end
      default: begin
        sel_be    = 4'b1111;
        sel_wdata = d_wdata;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= SRC_DATA;
      last_grant <= SRC_DATA;
      size_q     <= '0;
      off_q      <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            owner  <= pick_fetch ? SRC_FETCH : SRC_DATA;
            size_q <= sel_size;
            off_q  <= sel_addr[1:0];
            if (sel_err) begin
              // Rejected accesses complete immediately without touching the port.
              state <= S_DONE;
              if (pick_fetch) begin
                if_valid <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end else begin
                d_valid <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= sel_be;
              mem_wdata <= sel_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state <= S_DONE;
            if (owner == SRC_FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= mem_we ? '0 : ld_ext;
            end
          end
        end
        S_DONE: begin
          if_valid   <= 1'b0;
          if_err     <= 1'b0;
          d_valid    <= 1'b0;
          d_err      <= 1'b0;
          last_grant <= owner;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected completions,
// an independent monitor pops and compares on every if_valid/d_valid pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_size;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;
  exp_t sb[$];

  function automatic void push(input logic is_d, input logic [31:0] rd, input logic err,
                               input logic chk_rd);
    exp_t e;
    e.is_d = is_d; e.rdata = rd; e.err = err; e.chk_rd = chk_rd;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: grant after gnt_delay cycles of mem_req, respond rv_delay cycles later.
  int          gnt_delay = 0, rv_delay = 0, gnt_wait = 0, rv_wait = 0;
  bit          rv_pending = 0;
  logic [31:0] rd_val = '0;

  task automatic set_mem(input int gd, input int rd, input logic [31:0] val);
    gnt_delay = gd; gnt_wait = gd; rv_delay = rd; rd_val = val;
  endtask

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_val;
          rv_pending = 0;
        end else rv_wait--;
      end else if (mem_req) begin
        if (gnt_wait == 0) begin
          mem_gnt    = 1'b1;
          rv_pending = 1;
          rv_wait    = rv_delay;
          gnt_wait   = gnt_delay;
        end else gnt_wait--;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n && (if_valid || d_valid)) begin
      exp_t        e;
      logic        a_d, a_err;
      logic [31:0] a_rd;
      a_d   = d_valid;
      a_rd  = d_valid ? d_rdata : if_rdata;
      a_err = d_valid ? d_err : if_err;
      checks++;
      if (if_valid && d_valid) begin
        errors++;
        $display("FAIL both_valid: got if_valid=1 d_valid=1 expected one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got src=%0d rdata=%h err=%0d expected none", a_d, a_rd, a_err);
      end else begin
        e = sb.pop_front();
        if (a_d !== e.is_d || a_err !== e.err || (e.chk_rd && a_rd !== e.rdata)) begin
          errors++;
          $display("FAIL sb_completion: got src=%0d rdata=%h err=%0d expected src=%0d rdata=%h err=%0d",
                   a_d, a_rd, a_err, e.is_d, e.rdata, e.err);
        end
      end
    end
  end

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  bit          seen_req, unstable;
  int          req_cycles;
  int          lat;

  task automatic wait_valid(output int l);
    l = 0; seen_req = 0; unstable = 0; req_cycles = 0;
    do begin
      @(negedge clk);
      l++;
      if (mem_req) begin
        if (!seen_req) begin
          cap_addr = mem_addr; cap_be = mem_be; cap_we = mem_we; cap_wdata = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} != {cap_addr, cap_be, cap_we, cap_wdata})
          unstable = 1;
        seen_req = 1;
        req_cycles++;
      end
    end while (!(if_valid || d_valid) && l < 60);
    if (!(if_valid || d_valid)) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid after %0d cycles expected a valid", l);
    end
  endtask

  task automatic run_f(input logic [31:0] a, output int l);
    if_addr = a; if_req = 1'b1;
    wait_valid(l);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] sz, output int l);
    d_we = we; d_addr = a; d_wdata = wd; d_size = sz; d_req = 1'b1;
    wait_valid(l);
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_size = 3'b010;
    set_mem(0, 0, 32'h11223344);
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ctl", {26'd0, mem_we, mem_be, if_valid}, 0);
    chk("rst_flags", {29'd0, if_err, d_valid, d_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Both held from reset: fetch, data, fetch, data at one access per 4 cycles.
    push(0, 32'h11223344, 0, 1); push(1, 32'h11223344, 0, 1);
    push(0, 32'h11223344, 0, 1); push(1, 32'h11223344, 0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      chk(i == 0 ? "tie_first_lat" : "tie_b2b_lat", lat, i == 0 ? 3 : 4);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    set_mem(0, 0, 32'hDEADBEEF);
    push(0, 32'hDEADBEEF, 0, 1);
    run_f(32'h100, lat);
    chk("fetch_lat", lat, 3);
    chk("fetch_addr", cap_addr, 32'h100);
    chk("fetch_be_we", {cap_be, cap_we}, 5'b11110);
    chk("fetch_req_cycles", req_cycles, 1);

    set_mem(0, 0, 32'hFFFFFFFF);
    push(1, 32'h0, 0, 1);
    run_d(1'b1, 32'h203, 32'h000000A5, 3'b000, lat);
    chk("sb_lat", lat, 3);
    chk("sb_addr", cap_addr, 32'h200);
    chk("sb_be_we", {cap_be, cap_we}, 5'b10001);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);

    push(1, 32'h0, 0, 1);
    run_d(1'b1, 32'h202, 32'h1234BEEF, 3'b001, lat);
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);

    set_mem(0, 0, 32'h80011234);
    push(1, 32'hFFFF8001, 0, 1);
    run_d(1'b0, 32'h102, 32'h0, 3'b001, lat);
    chk("lh_addr", cap_addr, 32'h100);
    chk("lh_be_we", {cap_be, cap_we}, 5'b11000);
    push(1, 32'h00008001, 0, 1);
    run_d(1'b0, 32'h102, 32'h0, 3'b101, lat);

    set_mem(0, 0, 32'h12347F56);
    push(1, 32'h0000007F, 0, 1);
    run_d(1'b0, 32'h101, 32'h0, 3'b000, lat);
    chk("lb_be", cap_be, 4'b0010);
    set_mem(0, 0, 32'h00008000);
    push(1, 32'hFFFFFF80, 0, 1);
    run_d(1'b0, 32'h101, 32'h0, 3'b000, lat);
    set_mem(0, 0, 32'hF0000000);
    push(1, 32'h000000F0, 0, 1);
    run_d(1'b0, 32'h103, 32'h0, 3'b100, lat);
    chk("lbu_be", cap_be, 4'b1000);

    push(1, 32'h0, 1, 1);
    run_d(1'b0, 32'h102, 32'h0, 3'b010, lat);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_noreq", req_cycles, 0);
    push(0, 32'h0, 1, 0);
    run_f(32'h6, lat);
    chk("if_mis_lat", lat, 1);
    chk("if_mis_noreq", req_cycles, 0);
    push(1, 32'h0, 1, 1);
    run_d(1'b0, 32'h100, 32'h0, 3'b011, lat);
    chk("ld_illegal_noreq", req_cycles, 0);
    push(1, 32'h0, 1, 1);
    run_d(1'b1, 32'h100, 32'h0, 3'b100, lat);
    chk("st_illegal_noreq", req_cycles, 0);

    set_mem(5, 2, 32'h0);
    push(1, 32'h0, 0, 1);
    run_d(1'b1, 32'h300, 32'hCAFEF00D, 3'b010, lat);
    chk("stall_lat", lat, 10);
    chk("stall_req_cycles", req_cycles, 6);
    chk("stall_stable", {31'd0, unstable}, 0);
    chk("stall_wdata", cap_wdata, 32'hCAFEF00D);

    // Reset while the request is still waiting for grant.
    set_mem(20, 0, 32'h0);
    if_addr = 32'h500; if_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstreq_before", {31'd0, mem_req}, 1);
    rst_n = 1'b0;
    #1;
    chk("rstreq_drop", {31'd0, mem_req}, 0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while waiting for the response; the late rvalid must be ignored.
    set_mem(0, 6, 32'h55555555);
    d_we = 1'b0; d_addr = 32'h400; d_size = 3'b010; d_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    chk("rstwait_mem", {mem_req, mem_we, mem_be, 26'd0}, 0);
    chk("rstwait_addr", mem_addr, 0);
    chk("rstwait_valid", {30'd0, if_valid, d_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_valid || d_valid || mem_req) vcount++;
    end
    chk("late_rvalid_ignored", vcount, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
